// File: rtl/rv32_mod_issue_scoreboard.sv
// Register-hazard scoreboard between decode and execute: tracks in-flight rd writes, throttles issue.
// Latency: hazard checks and issue_ready are combinational; pending/outstanding update one edge after fire/writeback.
// Backpressure: issue_ready drops on RAW, WAW, a full write budget or flush; stalled instructions hold no state here.
module rv32_mod_issue_scoreboard #(
    parameter int MAX_OUTSTANDING = 4,
    parameter bit WB_BYPASS       = 1'b1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   issue_valid,
    input  logic [4:0]                             issue_rs1,
    input  logic [4:0]                             issue_rs2,
    input  logic [4:0]                             issue_rd,
    output logic                                   issue_ready,
    input  logic                                   wb_valid,
    input  logic [4:0]                             wb_index,
    input  logic                                   flush,
    output logic [31:0]                            pending,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   stall_raw,
    output logic                                   stall_waw,
    output logic                                   stall_full,
    output logic                                   wb_spurious
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);

    logic [31:1]   pend_q;
    logic [OW-1:0] cnt_q;
    logic          spur_q;

    logic [31:0]   eff;
    logic          wb_ok;
    logic          bypass_hit;
    logic [OW-1:0] cnt_eff;
    logic          fire;
    logic          do_set;
    logic          do_clr;
    logic [31:0]   set_mask;
    logic [31:0]   clr_mask;
    logic [31:0]   pend_nxt;
    logic [OW-1:0] cnt_nxt;

    assign pending     = {pend_q, 1'b0};
    assign outstanding = cnt_q;
    assign wb_spurious = spur_q;

    // Hazard view and stall causes; a writeback this cycle can release its register early when bypassing.
    always_comb begin
        wb_ok      = wb_valid && (wb_index != 5'd0) && pending[wb_index];
        bypass_hit = WB_BYPASS && wb_ok;
        eff        = pending;
        if (bypass_hit) begin
            eff[wb_index] = 1'b0;
        end
        cnt_eff     = bypass_hit ? (cnt_q - OW'(1)) : cnt_q;
        stall_raw   = eff[issue_rs1] | eff[issue_rs2];
        stall_waw   = (issue_rd != 5'd0) && eff[issue_rd];
        stall_full  = (issue_rd != 5'd0) && (cnt_eff == MAX_CNT);
        issue_ready = !flush && !stall_raw && !stall_waw && !stall_full;
    end

    // Next-state for the busy bitmap and count; a same-register set beats a clear so the bit stays busy.
    always_comb begin
        fire     = issue_valid && issue_ready;
        do_set   = fire && (issue_rd != 5'd0);
        do_clr   = wb_ok && !flush;
        set_mask = '0;
        clr_mask = '0;
        if (do_set) begin
            set_mask[issue_rd] = 1'b1;
        end
        if (do_clr) begin
            clr_mask[wb_index] = 1'b1;
        end
        pend_nxt = (pending & ~clr_mask) | set_mask;
        cnt_nxt  = cnt_q + (do_set ? OW'(1) : OW'(0)) - (do_clr ? OW'(1) : OW'(0));
    end

    // State registers; flush discards everything in flight and suppresses the spurious pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
            spur_q <= 1'b0;
        end else if (flush) begin
            pend_q <= '0;
            cnt_q  <= '0;
            spur_q <= 1'b0;
        end else begin
            pend_q <= pend_nxt[31:1];
            cnt_q  <= cnt_nxt;
            spur_q <= wb_valid && !wb_ok;
        end
    end

endmodule

// File: tb/tb_rv32_mod_issue_scoreboard.sv
// Directed bench for rv32_mod_issue_scoreboard (MAX_OUTSTANDING=4, WB_BYPASS=1).
// Inputs change 1ns after a rising edge; combinational outputs sampled 1ns later, registered ones after the next edge.
// Every comparison is an immediate assertion with hand-computed expectations.
module tb_rv32_mod_issue_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_index;
    logic        flush;
    logic [31:0] pending;
    logic [2:0]  outstanding;
    logic        stall_raw, stall_waw, stall_full;
    logic        wb_spurious;

    int vectors = 0;
    int miscompares = 0;

    rv32_mod_issue_scoreboard #(.MAX_OUTSTANDING(4), .WB_BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_index(wb_index), .flush(flush),
        .pending(pending), .outstanding(outstanding),
        .stall_raw(stall_raw), .stall_waw(stall_waw), .stall_full(stall_full),
        .wb_spurious(wb_spurious)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic wv, input logic [4:0] wi);
        issue_valid = v;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
        issue_rd    = rd;
        wb_valid    = wv;
        wb_index    = wi;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        check("reset_pending", pending, 32'h0);
        check("reset_outstanding", {29'd0, outstanding}, 32'd0);
        check("reset_spurious", {31'd0, wb_spurious}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("ready_after_reset", {31'd0, issue_ready}, 32'd1);

        // RAW with same-cycle writeback bypass
        drive(1, 0, 0, 5, 0, 0);
        step();
        check("rd5_pending", pending, 32'h20);
        check("rd5_outstanding", {29'd0, outstanding}, 32'd1);
        drive(1, 5, 0, 0, 0, 0);
        check("raw_stall", {31'd0, stall_raw}, 32'd1);
        check("raw_ready", {31'd0, issue_ready}, 32'd0);
        drive(1, 5, 0, 0, 1, 5);
        check("bypass_ready", {31'd0, issue_ready}, 32'd1);
        check("bypass_raw", {31'd0, stall_raw}, 32'd0);
        step();
        check("wb5_pending", pending, 32'h0);
        check("wb5_outstanding", {29'd0, outstanding}, 32'd0);

        // WAW, zero indices, same-register set/clear collision
        drive(1, 0, 0, 7, 0, 0);
        step();
        drive(1, 0, 0, 7, 0, 0);
        check("waw_stall", {31'd0, stall_waw}, 32'd1);
        check("waw_ready", {31'd0, issue_ready}, 32'd0);
        step();
        check("waw_hold_pending", pending, 32'h80);
        check("waw_hold_outstanding", {29'd0, outstanding}, 32'd1);
        drive(1, 0, 0, 0, 0, 0);
        check("zero_idx_ready", {31'd0, issue_ready}, 32'd1);
        drive(1, 0, 0, 7, 1, 7);
        check("waw_bypass_ready", {31'd0, issue_ready}, 32'd1);
        step();
        check("collide_pending", pending, 32'h80);
        check("collide_outstanding", {29'd0, outstanding}, 32'd1);
        drive(0, 0, 0, 0, 1, 7);
        step();
        check("wb7_pending", pending, 32'h0);
        check("wb7_spurious", {31'd0, wb_spurious}, 32'd0);

        // Outstanding budget
        for (int r = 1; r <= 4; r++) begin
            drive(1, 0, 0, 5'(r), 0, 0);
            step();
        end
        check("full_pending", pending, 32'h1E);
        check("full_outstanding", {29'd0, outstanding}, 32'd4);
        drive(1, 0, 0, 6, 0, 0);
        check("full_stall", {31'd0, stall_full}, 32'd1);
        check("full_ready", {31'd0, issue_ready}, 32'd0);
        drive(1, 9, 0, 0, 0, 0);
        check("full_rd0_ready", {31'd0, issue_ready}, 32'd1);
        check("full_rd0_stall", {31'd0, stall_full}, 32'd0);
        step();
        check("full_rd0_pending", pending, 32'h1E);
        drive(1, 0, 0, 6, 1, 2);
        check("full_bypass_ready", {31'd0, issue_ready}, 32'd1);
        step();
        check("swap_pending", pending, 32'h5A);
        check("swap_outstanding", {29'd0, outstanding}, 32'd4);

        // Spurious writebacks
        drive(0, 0, 0, 0, 1, 5);
        step();
        check("spur_np_pulse", {31'd0, wb_spurious}, 32'd1);
        check("spur_np_pending", pending, 32'h5A);
        check("spur_np_outstanding", {29'd0, outstanding}, 32'd4);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("spur_np_end", {31'd0, wb_spurious}, 32'd0);
        drive(0, 0, 0, 0, 1, 0);
        step();
        check("spur_x0_pulse", {31'd0, wb_spurious}, 32'd1);
        check("spur_x0_pending", pending, 32'h5A);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("spur_x0_end", {31'd0, wb_spurious}, 32'd0);

        // Flush with issue and writeback in the same cycle
        drive(0, 0, 0, 0, 1, 1);
        step();
        check("pre_flush_pending", pending, 32'h58);
        check("pre_flush_outstanding", {29'd0, outstanding}, 32'd3);
        flush = 1'b1;
        drive(1, 0, 0, 8, 1, 9);
        check("flush_ready", {31'd0, issue_ready}, 32'd0);
        step();
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        check("flush_pending", pending, 32'h0);
        check("flush_outstanding", {29'd0, outstanding}, 32'd0);
        check("flush_spurious", {31'd0, wb_spurious}, 32'd0);

        // Asynchronous reset between edges
        for (int r = 8; r <= 11; r++) begin
            drive(1, 0, 0, 5'(r), 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        check("pre_rst_pending", pending, 32'hF00);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_pending", pending, 32'h0);
        check("async_rst_outstanding", {29'd0, outstanding}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", {31'd0, issue_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
